// File: rtl/fifo_arb_rr_wr.sv
// Round-robin write arbiter in front of a single FIFO write port, with packet
// locking: a requester that wins with a non-last beat keeps the port until its last beat.
module fifo_arb_rr_wr #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_WIDTH  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [REQ_NUM-1:0]            i_req_valid,
  input  logic [REQ_NUM-1:0]            i_req_last,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_data,
  output logic [REQ_NUM-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  output logic [REQ_WIDTH-1:0]          o_fifo_wr_id,
  output logic                          o_busy
);

  localparam logic [0:0]           ST_IDLE  = 1'b0;
  localparam logic [0:0]           ST_LOCK  = 1'b1;
  localparam logic [REQ_WIDTH-1:0] LAST_IDX = REQ_WIDTH'(REQ_NUM - 1);
  localparam logic [REQ_WIDTH:0]   NUM_EXT  = (REQ_WIDTH + 1)'(REQ_NUM);

  logic [0:0]           r_state;
  logic [REQ_WIDTH-1:0] r_ptr;
  logic [REQ_WIDTH-1:0] r_owner;

  logic [REQ_WIDTH-1:0] sel;
  logic [REQ_WIDTH-1:0] sel_next_ptr;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 fire;
  logic [REQ_WIDTH:0]   idx;

  // NOTE: every signal driven in always_comb gets a default at the top so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    idx       = '0;
    if (r_state == ST_LOCK) begin
      sel       = r_owner;
      sel_valid = i_req_valid[r_owner];
    end else begin
      // Scan from r_ptr upward; the sum is wrapped by REQ_NUM, not by 2^REQ_WIDTH.
      for (int i = 0; i < REQ_NUM; i++) begin
        idx = {1'b0, r_ptr} + (REQ_WIDTH + 1)'(i);
        if (idx >= NUM_EXT) idx = idx - NUM_EXT;
        if (!sel_valid && i_req_valid[idx[REQ_WIDTH-1:0]]) begin
          sel_valid = 1'b1;
          sel       = idx[REQ_WIDTH-1:0];
        end
      end
    end
  end

  assign sel_last     = i_req_last[sel];
  assign fire         = sel_valid && !i_fifo_full;
  assign sel_next_ptr = (sel == LAST_IDX) ? '0 : sel + REQ_WIDTH'(1);

  always_comb begin
    o_fifo_wr_data = '0;
    o_req_ready    = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (sel == REQ_WIDTH'(k)) begin
        o_fifo_wr_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_req_ready[k] = fire;
      end
    end
  end

  assign o_fifo_wr_en = fire;
  assign o_fifo_wr_id = sel;
  assign o_busy       = (r_state == ST_LOCK);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (fire) begin
      if (r_state == ST_IDLE) begin
        if (sel_last) begin
          r_ptr <= sel_next_ptr;
        end else begin
          r_state <= ST_LOCK;
          r_owner <= sel;
        end
      end else if (sel_last) begin
        // In LOCK sel equals r_owner, so sel_next_ptr is owner+1 wrapped.
        r_state <= ST_IDLE;
        r_ptr   <= sel_next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_fifo_arb_rr_wr.sv
// Scoreboard bench: directed requester beats are queued per source, expected
// writes are queued in grant order, and a monitor compares every FIFO write.
module tb_fifo_arb_rr_wr;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int DW = 32;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N*DW-1:0]   req_data;
  logic              fifo_full;
  logic              wr_en, busy;
  logic [DW-1:0]     wr_data;
  logic [1:0]        wr_id;

  logic [N3-1:0]     v3, rdy3;
  logic [N3*DW-1:0]  d3;
  logic              wr_en3, busy3;
  logic [DW-1:0]     wr_data3;
  logic [1:0]        wr_id3;

  beat_t src_q[N][$];
  exp_t  sb_q[$];
  exp_t  sb3_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_arb_rr_wr #(.REQ_NUM(N), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_last(req_last), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_fifo_full(fifo_full),
    .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data), .o_fifo_wr_id(wr_id),
    .o_busy(busy)
  );

  fifo_arb_rr_wr #(.REQ_NUM(N3), .DATA_WIDTH(DW)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(v3), .i_req_last({N3{1'b1}}), .i_req_data(d3),
    .o_req_ready(rdy3), .i_fifo_full(1'b0),
    .o_fifo_wr_en(wr_en3), .o_fifo_wr_data(wr_data3), .o_fifo_wr_id(wr_id3),
    .o_busy(busy3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input int id, input logic [DW-1:0] data, input logic b);
    exp_t e;
    e.id = 2'(id); e.data = data; e.busy = b;
    sb_q.push_back(e);
  endtask

  task automatic push_beat(input int k, input logic last, input logic [DW-1:0] data);
    beat_t b;
    b.last = last; b.data = data;
    src_q[k].push_back(b);
  endtask

  // Requesters present the head of their queue; idle sources show a marker word.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        req_valid[k]          = 1'b1;
        req_last[k]           = src_q[k][0].last;
        req_data[k*DW +: DW]  = src_q[k][0].data;
      end else begin
        req_valid[k]          = 1'b0;
        req_last[k]           = 1'b0;
        req_data[k*DW +: DW]  = 32'hA5A5_0000 + 32'(k);
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (rdy[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_empty(input string name);
    int cyc = 0;
    while (!all_empty() && cyc < 50) begin
      step();
      cyc++;
    end
    check({name, "_drain_timeout"}, 64'(all_empty()), 64'd1);
  endtask

  task automatic check_stall(input string name, input logic exp_busy);
    @(negedge clk);
    check({name, "_wr_en"}, 64'(wr_en), 64'd0);
    check({name, "_ready"}, 64'(req_ready), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'(exp_busy));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every FIFO write must match the next expected beat; busy is the
  // value seen during the beat's own cycle.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write_id", 64'(wr_id), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_id", 64'(wr_id), 64'(e.id));
        check("wr_data", 64'(wr_data), 64'(e.data));
        check("wr_busy", 64'(busy), 64'(e.busy));
        check("wr_ready_onehot", 64'(req_ready), 64'(4'b0001 << e.id));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wr_en3) begin
      if (sb3_q.size() == 0) begin
        check("n3_unexpected_write_id", 64'(wr_id3), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb3_q.pop_front();
        check("n3_wr_id", 64'(wr_id3), 64'(e.id));
        check("n3_wr_data", 64'(wr_data3), 64'(e.data));
        check("n3_ready_onehot", 64'(rdy3), 64'(3'b001 << e.id));
        check("n3_busy", 64'(busy3), 64'd0);
      end
    end
  end

  initial begin
    fifo_full = 1'b0;
    v3 = '0;
    for (int k = 0; k < N3; k++) d3[k*DW +: DW] = 32'h0000_C300 + 32'(k);
    drive();
    #12;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'hA5A5_0000);
    check("rst_wr_id", 64'(wr_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat fairness: ids 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) begin
        push_beat(k, 1'b1, 32'h1000_0000 + 32'(r*16 + k));
        expect_wr(k, 32'h1000_0000 + 32'(r*16 + k), 1'b0);
      end
    drive();
    run_until_empty("fair");

    // Move the pointer to 2 with one beat from req1.
    push_beat(1, 1'b1, 32'h2000_0011);
    expect_wr(1, 32'h2000_0011, 1'b0);
    drive();
    run_until_empty("ptr_move");

    // Packet lock: req2 A0..A2 while req0/req3 wait; then 3, then 0.
    push_beat(2, 1'b0, 32'hAAAA_0000);
    push_beat(2, 1'b0, 32'hAAAA_0001);
    push_beat(2, 1'b1, 32'hAAAA_0002);
    push_beat(0, 1'b1, 32'hBBBB_0000);
    push_beat(3, 1'b1, 32'hCCCC_0000);
    expect_wr(2, 32'hAAAA_0000, 1'b0);
    expect_wr(2, 32'hAAAA_0001, 1'b1);
    expect_wr(2, 32'hAAAA_0002, 1'b1);
    expect_wr(3, 32'hCCCC_0000, 1'b0);
    expect_wr(0, 32'hBBBB_0000, 1'b0);
    drive();
    run_until_empty("lock");
    @(negedge clk);
    check("lock_released_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Full stall inside req1's packet (pointer is 1 here).
    push_beat(1, 1'b0, 32'hDDDD_0000);
    push_beat(1, 1'b0, 32'hDDDD_0001);
    push_beat(1, 1'b1, 32'hDDDD_0002);
    push_beat(0, 1'b1, 32'hEEEE_0000);
    expect_wr(1, 32'hDDDD_0000, 1'b0);
    expect_wr(1, 32'hDDDD_0001, 1'b1);
    expect_wr(1, 32'hDDDD_0002, 1'b1);
    expect_wr(0, 32'hEEEE_0000, 1'b0);
    drive();
    step();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) check_stall("full", 1'b1);
    fifo_full = 1'b0;
    run_until_empty("full");

    // Owner gap: req1 locks, drops valid for 3 cycles, req2 waits.
    push_beat(1, 1'b0, 32'hF0F0_0000);
    push_beat(2, 1'b1, 32'h6060_0000);
    expect_wr(1, 32'hF0F0_0000, 1'b0);
    expect_wr(1, 32'hF0F0_0001, 1'b1);
    expect_wr(2, 32'h6060_0000, 1'b0);
    drive();
    step();
    for (int c = 0; c < 3; c++) check_stall("gap", 1'b1);
    push_beat(1, 1'b1, 32'hF0F0_0001);
    drive();
    run_until_empty("gap");

    // Reset mid-packet (pointer is 3): req3 writes H0,H1 then reset hits.
    push_beat(3, 1'b0, 32'h3030_0000);
    push_beat(3, 1'b0, 32'h3030_0001);
    push_beat(3, 1'b1, 32'h3030_0002);
    expect_wr(3, 32'h3030_0000, 1'b0);
    expect_wr(3, 32'h3030_0001, 1'b1);
    drive();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      push_beat(k, 1'b1, 32'h4040_0000 + 32'(k));
      expect_wr(k, 32'h4040_0000 + 32'(k), 1'b0);
    end
    drive();
    #1;
    check("post_rst_first_id", 64'(wr_id), 64'd0);
    run_until_empty("post_rst");

    // REQ_NUM=3 wrap: 0,1,2,0,1,2, never 3.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N3; k++) begin
        exp_t e;
        e.id = 2'(k); e.data = 32'h0000_C300 + 32'(k); e.busy = 1'b0;
        sb3_q.push_back(e);
      end
    v3 = '1;
    repeat (6) @(posedge clk);
    #1;
    v3 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("sb3_empty", 64'(sb3_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
